// File: rtl/dest_router.sv
// In-order result FIFO that routes each buffered word to one of NUM_DEST valid/ready consumers.
// Optional P32_DEST_ROUTER_ERR_EN adds a sticky err flag and a saturating drop_cnt for invalid indices.
module dest_router #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NUM_DEST = 3,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PTR_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic [WIDTH-1:0]          in_data,
  output logic [NUM_DEST-1:0]       out_valid,
  input  logic [NUM_DEST-1:0]       out_ready,
  output logic [NUM_DEST*WIDTH-1:0] out_data,
  output logic [PTR_W:0]            count
`ifdef P32_DEST_ROUTER_ERR_EN
  ,
  output logic                      err,
  output logic [7:0]                drop_cnt
`endif
);

  localparam int unsigned CNT_W = PTR_W + 1;

  logic [SEL_W-1:0]          sel_mem  [DEPTH];
  logic [WIDTH-1:0]          data_mem [DEPTH];
  logic [PTR_W-1:0]          rd_ptr, wr_ptr, rd_n, wr_n;
  logic [CNT_W-1:0]          cnt_n;
  logic [SEL_W-1:0]          head_sel, sel_n;
  logic [WIDTH-1:0]          data_n;
  logic                      push, pop, drop, hit, ready_n;
  logic [NUM_DEST-1:0]       valid_n;
  logic [NUM_DEST*WIDTH-1:0] odata_n;

  assign head_sel = sel_mem[rd_ptr];

  // Next pointers/count plus the head presentation for the following cycle.
  always_comb begin
    push    = in_valid && in_ready && !flush;
    drop    = (count != '0) && ({1'b0, head_sel} >= (SEL_W+1)'(NUM_DEST));
    hit     = |(out_valid & out_ready);
    pop     = (hit || drop) && !flush;
    rd_n    = rd_ptr;
    wr_n    = wr_ptr;
    cnt_n   = count;
    valid_n = '0;
    odata_n = '0;
    if (flush) begin
      rd_n  = '0;
      wr_n  = '0;
      cnt_n = '0;
    end else begin
      if (push) wr_n = wr_ptr + PTR_W'(1);
      if (pop)  rd_n = rd_ptr + PTR_W'(1);
      if (push && !pop)      cnt_n = count + CNT_W'(1);
      else if (!push && pop) cnt_n = count - CNT_W'(1);
    end
    // A push that leaves exactly one entry makes the incoming word the new head.
    if (push && cnt_n == CNT_W'(1)) begin
      sel_n  = in_sel;
      data_n = in_data;
    end else begin
      sel_n  = sel_mem[rd_n];
      data_n = data_mem[rd_n];
    end
    ready_n = cnt_n < CNT_W'(DEPTH);
    if (cnt_n != '0) begin
      for (int i = 0; i < NUM_DEST; i++) begin
        if ({1'b0, sel_n} == (SEL_W+1)'(i)) begin
          valid_n[i]                = 1'b1;
          odata_n[i*WIDTH +: WIDTH] = data_n;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      in_ready  <= 1'b0;
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      rd_ptr    <= rd_n;
      wr_ptr    <= wr_n;
      count     <= cnt_n;
      in_ready  <= ready_n;
      out_valid <= valid_n;
      out_data  <= odata_n;
    end
  end

  // Storage is never observed unless count says the slot is live.
  always_ff @(posedge clk) begin
    if (push) begin
      sel_mem[wr_ptr]  <= in_sel;
      data_mem[wr_ptr] <= in_data;
    end
  end

`ifdef P32_DEST_ROUTER_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop && !flush) begin
      err <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: doc/dest_router.md
Name: dest_router

Overview:
- Parametrised successor to the writeback destination selector in the project32 core.
- Accepts result words tagged with a destination index and buffers them in a small in-order FIFO.
- Delivers each word to exactly one of NUM_DEST consumers (register file, memory write port, PC, CSR, ...) using per-destination valid/ready handshakes.
- Sits between the execute stage and the writeback consumers, decoupling producer and consumer stalls.

Parameters:
- WIDTH, 32: data word width in bits.
- NUM_DEST, 3: number of destination channels; 1..2**SEL_W.
- SEL_W, 2: width of the destination index.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- PTR_W, 2: log2(DEPTH).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous discard of all buffered entries.
- in_valid  in  1  producer presents a word.
- in_ready  out  1  router can accept a word.
- in_sel  in  SEL_W  destination index for the word.
- in_data  in  WIDTH  result word.
- out_valid  out  NUM_DEST  per-destination valid; at most one bit set.
- out_ready  in  NUM_DEST  per-destination ready.
- out_data  out  NUM_DEST*WIDTH  flattened data; channel i occupies bits [i*WIDTH +: WIDTH].
- count  out  PTR_W+1  number of occupied FIFO entries.

Behaviour:
- Reset is asynchronous and active-low; one clock, with all state on the rising edge of clk.
- While rst_n is low: count=0, read/write pointers=0, out_valid=0, out_data=0, in_ready=0.
- in_ready is 1 from the first edge after rst_n rises whenever count<DEPTH.
- Push: on an edge with in_valid && in_ready && !flush, in_sel and in_data are written at the write pointer, the write pointer increments modulo DEPTH, and count increments unless a pop occurs in the same cycle.
- Full:
  - in_ready=0 when count==DEPTH, even if a pop occurs that cycle; there is no full-pass-through.
  - in_data is ignored while in_ready=0.
- Latency: there is no empty bypass. A word pushed at edge N is visible on its output at earliest in the cycle after edge N (1-cycle latency).
- Head presentation, when count>0 and the head index h<NUM_DEST:
  - out_valid[h]=1.
  - out_data channel h = head data.
  - All other out_valid bits are 0 and all other channels' data is 0.
- When count==0, out_valid=0 and all of out_data is 0; outputs never drive X.
- Pop:
  - On an edge with out_valid[h] && out_ready[h], the read pointer increments modulo DEPTH.
  - out_ready on non-selected channels is ignored.
- Ordering:
  - Strictly in-order across all destinations.
  - A stalled head blocks younger entries for other destinations (head-of-line blocking is required behaviour).
- Invalid index (head h>=NUM_DEST): no out_valid is asserted, and the entry is popped automatically at the next edge (1 cycle per dropped entry).
- Simultaneous push and pop with 0<count<DEPTH: both pointers advance and count is unchanged.
- Simultaneous push and pop with count==0: impossible, since nothing is presented while empty.
- Pointer wrap: pointers wrap naturally at DEPTH. Full and empty are distinguished by count, not by pointer equality.
- Flush:
  - On an edge with flush=1: count, the read pointer and the write pointer return to 0, and any in_valid that cycle is dropped.
  - From the next cycle, out_valid=0.
  - Flush takes priority over both push and pop; any pop handshake in the flush cycle is not honoured.
- Reset mid-operation: contents are discarded and no partial handshake completes. After reset release, behaviour matches the post-reset state above.

Optional Feature:
- Macro: P32_DEST_ROUTER_ERR_EN.
- When defined, two extra ports are added:
  - err  out  1: sticky; set on the edge where an invalid-index entry is dropped; cleared only by reset.
  - drop_cnt  out  8: counts dropped invalid-index entries; saturates at 255; reset to 0.
- When not defined, the ports and logic are absent, and invalid-index entries are still dropped silently as above.

Test Plan:
- Reset then single push (sel=0, data=32'hDEADBEEF, out_ready=3'b111) -> the next cycle shows out_valid=3'b001 and channel 0 data=DEADBEEF; popped at the following edge, count returns to 0.
- Four pushes sel=1 with out_ready=0 -> count=4, in_ready=0; a fifth push is not accepted. Raise out_ready[1] -> the words drain in order, one per cycle, and in_ready=1 the cycle after the first pop.
- Interleaved push sel=2 (data A) then sel=0 (data B), with out_ready=3'b001 -> out_valid=3'b100 persists with channel 0 idle (head-of-line blocking). Set out_ready=3'b100 -> A pops, then B appears on channel 0.
- Push sel=3 with NUM_DEST=3, followed by sel=1 data 5 -> no valid for the first entry, which drops in 1 cycle; then out_valid=3'b010 with data 5. With P32_DEST_ROUTER_ERR_EN: err=1 and drop_cnt=1.
- Fill 3 entries, then assert flush in the same cycle as a push and a ready pop -> count=0 next cycle, out_valid=0, and the flushed-cycle word is absent.
- Assert rst_n=0 asynchronously mid-stream with count=2 -> outputs zero immediately without waiting for a clock edge; after release, count=0 and in_ready=1.
